// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input path: controller state encoding and
// the byte-to-word scaling used by every block that feeds the FFT input RAM.
package fft_pkg;

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_GET_IM = 5'b00010,
      S_WRITE  = 5'b00100,
      S_START  = 5'b01000,
      S_BUSY   = 5'b10000
   } state_t;

   // Widest word any consumer may request; callers size-cast down to their width.
   localparam int EXT_W = 64;

   // Sign-extended byte scaled by 256: {sign copies, byte, 8'h00}.
   function automatic logic [EXT_W-1:0] scale_byte(input logic [7:0] b);
      return {{(EXT_W-16){b[7]}}, b, 8'h00};
   endfunction

endpackage

// File: rtl/bit_rev_addr.sv
// Purely combinational SIZE-bit address reversal, shared with the FFT read side.
module bit_rev_addr #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] addr,
   output logic [SIZE-1:0] rev
);

   genvar gi;
   generate
      for (gi = 0; gi < SIZE; gi++) begin : g_rev
         assign rev[gi] = addr[SIZE-1-gi];
      end
   endgenerate

endmodule

// File: rtl/fft_frame_ctrl.sv
// Assembles real/imag byte pairs into FFT input words, writes them at
// bit-reversed addresses, and hands each complete frame to the FFT core.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int bit_width = 32,   // 16..64
   parameter int N         = 16,
   parameter int SIZE      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           byte_i,
   input  logic                 byte_valid,
   input  logic                 abort,
   input  logic                 fft_done,
   output logic                 wr_en,
   output logic [SIZE-1:0]      wr_addr,
   output logic [bit_width-1:0] wr_re,
   output logic [bit_width-1:0] wr_im,
   output logic                 fft_start,
   output logic                 busy,
   output logic [7:0]           drop_cnt
);

   state_t          state_reg;
   state_t          state_next;
   logic [SIZE-1:0] sample_cnt_reg;
   logic [7:0]      re_reg;
   logic [SIZE-1:0] rev_addr;
   logic            drop;

   bit_rev_addr #(.SIZE(SIZE)) u_bit_rev (
      .addr (sample_cnt_reg),
      .rev  (rev_addr)
   );

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE:   if (byte_valid) state_next = S_GET_IM;
         S_GET_IM: if (byte_valid) state_next = S_WRITE;
         S_WRITE:  state_next = (sample_cnt_reg == SIZE'(N-1)) ? S_START : S_IDLE;
         S_START:  state_next = S_BUSY;
         S_BUSY:   if (fft_done) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   // A byte arriving alongside abort is discarded silently, not counted as dropped.
   assign drop = byte_valid && !abort &&
                 (state_reg inside {S_WRITE, S_START, S_BUSY});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         sample_cnt_reg <= '0;
         re_reg         <= '0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_re          <= '0;
         wr_im          <= '0;
         fft_start      <= 1'b0;
         busy           <= 1'b0;
         drop_cnt       <= '0;
      end else begin
         state_reg <= state_next;

         // Outputs are registered from the next state so they line up with it.
         wr_en     <= (state_next == S_WRITE);
         fft_start <= (state_next == S_START);
         busy      <= (state_next == S_BUSY);

         if (state_reg == S_IDLE && byte_valid && !abort)
            re_reg <= byte_i;

         if (state_next == S_WRITE) begin
            wr_addr <= rev_addr;
            wr_re   <= bit_width'(scale_byte(re_reg));
            wr_im   <= bit_width'(scale_byte(byte_i));
         end

         // N is a power of two, so the counter wraps to 0 after N-1 on its own.
         if (abort)
            sample_cnt_reg <= '0;
         else if (state_reg == S_WRITE)
            sample_cnt_reg <= sample_cnt_reg + 1'b1;

         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule
